aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative Rijndael key schedule, one 32-bit word per cycle. Generates all Nb*(Nr+1) round-key words into internal storage. Sits directly upstream of the cipher round datapath and feeds it round keys through a registered read port. The round count comes from the shared package Nr(Nb,Nk) function, with Nk selected at run time.

Parameters:
NB, 4, block size in 32-bit words; legal values 4, 6, 8; sets the number of words generated.
MAXW, 120, storage depth in words (8*15); fixed.

Ports:
clock  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request expansion; sampled only in IDLE
key_len  in  2  0 = 128-bit key (Nk=4), 1 = 192-bit (Nk=6), 2 = 256-bit (Nk=8), 3 = illegal
key  in  256  cipher key, MSB-first; word j = key[255-32j -: 32]; unused low words ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word is written
error  out  1  one-cycle pulse: start with an illegal key_len or Nr(NB,Nk)==0
nr  out  4  round count latched at an accepted start
rk_raddr  in  7  word read address
rk_rdata  out  32  word at rk_raddr, registered, 1-cycle latency

Behaviour:
- Reset: state IDLE; busy=0, done=0, error=0, nr=0, rk_rdata=0, counters=0. Storage contents are undefined and are not cleared.
- FSM states: IDLE, LOAD, EXPAND, FIN.
- IDLE + start + legal: latch key, Nk, nr=Nr(NB,Nk), total=NB*(nr+1). Set i=0, rcon=0x01, go to LOAD, busy=1.
- IDLE + start + illegal: error=1 for one cycle, stay in IDLE.
- LOAD: write key word i to mem[i] and shift it into an 8-word window. i++ each cycle. After i==Nk-1, go to EXPAND.
- EXPAND: temp=w[i-1].
  - If i mod Nk==0: temp=SubWord(RotWord(temp)) xor {rcon,24'h0}, then rcon=xtime(rcon) (GF(2^8), poly 0x11b).
  - Else if Nk==8 and i mod Nk==4: temp=SubWord(temp).
  - w[i]=w[i-Nk] xor temp. Write mem[i] and the window. i++.
  - After i==total-1, go to FIN.
- i mod Nk is tracked by a wrapping counter; no divider.
- FIN: done=1, busy=0, go to IDLE.
- Latency: accepted start at edge k. Word i is written at edge k+1+i. done is high in the cycle after edge k+total. AES-128 with NB=4: 44 words, done 45 cycles after start.
- start while busy is ignored. No queueing.
- Reads: rk_rdata <= mem[rk_raddr] every cycle, including while busy.
  - Same-address read and write in one cycle returns the old data.
  - rk_raddr >= MAXW returns 0.
- reset mid-expansion: FSM to IDLE immediately, outputs to reset values, partial words remain in storage.
- rcon is 8-bit and wraps naturally via xtime (0x80 -> 0x1b -> 0x36 ...). This is required for NB>4, where more than 10 rcon steps occur.

Optional Feature:
AES_KEY_ZEROIZE_EN
- Defined: adds input port zeroize (1 bit) and state ZERO.
  - zeroize in any state aborts an expansion in progress.
  - ZERO writes 0 to mem[0..MAXW-1], one word per cycle, with busy=1, then returns to IDLE with no done pulse.
  - zeroize has priority over start.
- Undefined: no port, no state; storage is only overwritten by expansion.

Decomposition:
- Package aes_func gains:
  - key_len encoding constants;
  - MAXW;
  - function Nk(key_len);
  - function xtime(byte);
  - function RotWord(word).
- Existing function Nr is reused unchanged.
- Sub-module aes_sbox: combinational byte S-box. Instantiated 4 times for SubWord.

Test Plan:
1. NB=4, key_len=0, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> nr=10, done 45 cycles after start; w[4]=a0fafe17, w[43]=b6630ca6.
2. NB=4, key_len=1, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> nr=12; w[6]=fe0c91f7, w[51]=01002202.
3. NB=4, key_len=2, key 603deb10 ... 0914dff4 -> nr=14; w[8]=9ba35411, w[59]=706c631e.
4. key_len=3 start -> error pulse for 1 cycle, busy stays 0, nr unchanged; a second start pulsed mid-expansion is ignored and done arrives on the original schedule.
5. reset asserted at word 20 of test 1 -> outputs to reset values immediately; a restart produces the correct w[43].
6. NB=8, key_len=0 -> nr=14, 120 words written, rcon sequence passes through 0x1b, 0x36, 0x6c; results match the software model.

Source files
------------

// File: rtl/aes_func_pkg.sv
// ---------------------------------------------------------------------------
// aes_func : shared AES helper package.
//   - key_len encodings and the key-schedule storage depth MAXW
//   - Nr(Nb, Nk) : Rijndael round count, 0 for an unsupported combination
//   - Nk(key_len), xtime(byte), RotWord(word) : key-schedule helpers
//   - ks_state_e : key-expansion FSM states
// Optional build macro: AES_KEY_ZEROIZE_EN adds the ZERO state to ks_state_e.
// ---------------------------------------------------------------------------
package aes_func;

  localparam int MAXW = 120;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

`ifdef AES_KEY_ZEROIZE_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_FIN    = 3'd3,
    ST_ZERO   = 3'd4
  } ks_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_FIN    = 3'd3
  } ks_state_e;
`endif

  // Rijndael round count: max(Nb, Nk) + 6, or 0 when either size is illegal.
  function automatic logic [3:0] Nr(input int nb, input int nk);
    if (!(nb == 4 || nb == 6 || nb == 8)) return 4'd0;
    if (!(nk == 4 || nk == 6 || nk == 8)) return 4'd0;
    return (nb > nk) ? 4'(nb + 6) : 4'(nk + 6);
  endfunction

  // Key length in 32-bit words; 0 marks the illegal encoding.
  function automatic logic [3:0] Nk(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: return 4'd4;
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotation by one byte.
  function automatic logic [31:0] RotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox : combinational AES forward S-box (one byte).
//   byte_i : input byte
//   byte_o : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand : iterative Rijndael key schedule, one 32-bit word per cycle.
// All NB*(Nr+1) round-key words are generated into internal storage and
// served to the round datapath through a registered read port.
//
// Parameters
//   NB   : block size in words (4, 6 or 8)
//   MAXW : storage depth in words (fixed at 120)
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : expansion request, sampled only in IDLE
//   key_len  : 0=128, 1=192, 2=256 bit key, 3=illegal
//   key      : cipher key, word j at key[255-32j -: 32]
//   busy     : expansion (or zeroize sweep) in progress
//   done     : one-cycle pulse after the last word is written
//   error    : one-cycle pulse for a rejected start
//   nr       : round count latched at an accepted start
//   rk_raddr : word read address
//   rk_rdata : word at rk_raddr, one cycle latency, 0 beyond MAXW-1
//   zeroize  : (only with AES_KEY_ZEROIZE_EN) abort and clear storage
// Optional build macro: AES_KEY_ZEROIZE_EN
// ---------------------------------------------------------------------------
module aes_key_expand
  import aes_func::*;
#(
  parameter int NB   = 4,
  parameter int MAXW = aes_func::MAXW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   nr,
  input  logic [6:0]   rk_raddr,
  output logic [31:0]  rk_rdata
);

  ks_state_e    state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic [2:0]   imod_q, imod_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [6:0]   total_q, total_d;
  logic         err_q, err_d;
  logic [31:0]  rdata_q;

  logic [255:0] key_q;
  logic [31:0]  win_q [8];
  logic [31:0]  mem_q [MAXW];

  logic [3:0]   nk_sel;
  logic [3:0]   nr_sel;
  logic [6:0]   total_sel;
  logic         start_ok;
  logic         accept;

  logic [2:0]   imod_next;
  logic [2:0]   back_idx;
  logic [31:0]  load_w;
  logic [31:0]  prev_w;
  logic [31:0]  back_w;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_w;
  logic [31:0]  new_w;

  logic         wr_en;
  logic         win_we;
  logic [31:0]  wr_data;

  // Start qualification: an unsupported NB or key_len yields Nr == 0.
  assign nk_sel    = Nk(key_len);
  assign nr_sel    = Nr(NB, int'(nk_sel));
  assign start_ok  = (nr_sel != 4'd0);
  assign total_sel = 7'(NB * (int'(nr_sel) + 1));

  // i mod Nk, kept as a wrapping counter alongside i.
  assign imod_next = (({1'b0, imod_q} + 4'd1) == nk_q) ? 3'd0 : imod_q + 3'd1;

  // Window: win_q[0] holds w[i-1], win_q[Nk-1] holds w[i-Nk].
  assign back_idx = 3'(nk_q - 4'd1);
  assign prev_w   = win_q[0];
  assign back_w   = win_q[back_idx];
  assign load_w   = key_q[{3'd7 - idx_q[2:0], 5'd0} +: 32];

  assign sub_in = (imod_q == 3'd0) ? RotWord(prev_w) : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (sub_in[8*b +: 8]),
      .byte_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    if (imod_q == 3'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && imod_q == 3'd4) begin
      temp_w = sub_out;
    end
  end

  assign new_w = back_w ^ temp_w;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    total_d = total_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    wr_en   = 1'b0;
    win_we  = 1'b0;
    wr_data = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            accept  = 1'b1;
            nk_d    = nk_sel;
            nr_d    = nr_sel;
            total_d = total_sel;
            idx_d   = 7'd0;
            imod_d  = 3'd0;
            rcon_d  = 8'h01;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        wr_en   = 1'b1;
        win_we  = 1'b1;
        wr_data = load_w;
        idx_d   = idx_q + 7'd1;
        imod_d  = imod_next;
        if (idx_q == ({3'b000, nk_q} - 7'd1)) state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        wr_en   = 1'b1;
        win_we  = 1'b1;
        wr_data = new_w;
        idx_d   = idx_q + 7'd1;
        imod_d  = imod_next;
        if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (idx_q == (total_q - 7'd1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
`ifdef AES_KEY_ZEROIZE_EN
      ST_ZERO: begin
        wr_en   = 1'b1;
        wr_data = 32'h0;
        idx_d   = idx_q + 7'd1;
        if (idx_q == 7'(MAXW - 1)) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize overrides everything, including a start in the same cycle.
    if (zeroize) begin
      accept  = 1'b0;
      err_d   = 1'b0;
      idx_d   = 7'd0;
      state_d = ST_ZERO;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 7'd0;
      imod_q  <= 3'd0;
      rcon_q  <= 8'h00;
      nk_q    <= 4'd0;
      nr_q    <= 4'd0;
      total_q <= 7'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      total_q <= total_d;
      err_q   <= err_d;
      // Read-before-write: a same-cycle write to rk_raddr returns the old word.
      rdata_q <= (rk_raddr < 7'(MAXW)) ? mem_q[rk_raddr] : 32'h0;
    end
  end

  // Datapath storage carries no reset; partial words survive an abort.
  always_ff @(posedge clock) begin
    if (accept) key_q <= key;
    if (win_we) begin
      win_q[0] <= wr_data;
      for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
    end
    if (wr_en) mem_q[idx_q] <= wr_data;
  end

`ifdef AES_KEY_ZEROIZE_EN
  assign busy = (state_q == ST_LOAD) || (state_q == ST_EXPAND) || (state_q == ST_ZERO);
`else
  assign busy = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
`endif
  assign done     = (state_q == ST_FIN);
  assign error    = err_q;
  assign nr       = nr_q;
  assign rk_rdata = rdata_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [0:255][7:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start4, busy4, done4, err4;
  logic [1:0]   klen4;
  logic [255:0] key4;
  logic [3:0]   nr4;
  logic [6:0]   raddr4;
  logic [31:0]  rdata4;

  logic         start8, busy8, done8, err8;
  logic [1:0]   klen8;
  logic [255:0] key8;
  logic [3:0]   nr8;
  logic [6:0]   raddr8;
  logic [31:0]  rdata8;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m8 [120];

  aes_key_expand #(.NB(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .key_len(klen4), .key(key4),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .busy(busy4), .done(done4), .error(err4), .nr(nr4),
    .rk_raddr(raddr4), .rk_rdata(rdata4)
  );

  aes_key_expand #(.NB(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .key_len(klen8), .key(key8),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .busy(busy8), .done(done8), .error(err8), .nr(nr8),
    .rk_raddr(raddr8), .rk_rdata(rdata8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read4(input logic [6:0] a, output logic [31:0] d);
    raddr4 = a;
    tick();
    d = rdata4;
  endtask

  task automatic read8(input logic [6:0] a, output logic [31:0] d);
    raddr8 = a;
    tick();
    d = rdata8;
  endtask

  task automatic start4_go(input logic [1:0] kl, input logic [255:0] k);
    klen4  = kl;
    key4   = k;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Counts edges from the one that sampled start; bounded.
  task automatic wait_done4(input int c0, output int cnt);
    cnt = c0;
    while (done4 !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {SBOX_T[w[31:24]], SBOX_T[w[23:16]], SBOX_T[w[15:8]], SBOX_T[w[7:0]]};
  endfunction

  // Straightforward FIPS-197 style schedule for Nk=4, 120 words.
  task automatic build_model(input logic [255:0] k);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 120; i++) begin
      if (i < 4) begin
        m8[i] = k[255 - 32*i -: 32];
      end else begin
        t = m8[i-1];
        if (i % 4 == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        end
        m8[i] = m8[i-4] ^ t;
      end
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] d;

    reset  = 1'b1;
    start4 = 1'b0; klen4 = 2'd0; key4 = '0; raddr4 = 7'd0;
    start8 = 1'b0; klen8 = 2'd0; key8 = '0; raddr8 = 7'd0;
    tick();
    tick();
    chk("rst_busy",  32'(busy4),  32'h0);
    chk("rst_done",  32'(done4),  32'h0);
    chk("rst_error", 32'(err4),   32'h0);
    chk("rst_nr",    32'(nr4),    32'h0);
    chk("rst_rdata", rdata4,      32'h0);
    chk("rst_busy8", 32'(busy8),  32'h0);
    chk("rst_rdata8", rdata8,     32'h0);
    reset = 1'b0;
    tick();

    // AES-128
    start4_go(2'd0, K128);
    chk("t1_busy", 32'(busy4), 32'h1);
    wait_done4(1, cnt);
    chk("t1_cycles", 32'(cnt), 32'd45);
    chk("t1_done", 32'(done4), 32'h1);
    chk("t1_nr", 32'(nr4), 32'd10);
    chk("t1_busy_fin", 32'(busy4), 32'h0);
    tick();
    chk("t1_done_pulse", 32'(done4), 32'h0);
    read4(7'd0, d);   chk("t1_w0", d, 32'h2b7e1516);
    read4(7'd3, d);   chk("t1_w3", d, 32'h09cf4f3c);
    read4(7'd4, d);   chk("t1_w4", d, 32'ha0fafe17);
    read4(7'd5, d);   chk("t1_w5", d, 32'h88542cb1);
    read4(7'd43, d);  chk("t1_w43", d, 32'hb6630ca6);
    read4(7'd120, d); chk("rd_oob120", d, 32'h0);
    read4(7'd127, d); chk("rd_oob127", d, 32'h0);

    // Illegal key length
    start4_go(2'd3, K128);
    chk("t4_error", 32'(err4), 32'h1);
    chk("t4_busy", 32'(busy4), 32'h0);
    chk("t4_nr", 32'(nr4), 32'd10);
    tick();
    chk("t4_error_pulse", 32'(err4), 32'h0);
    chk("t4_busy2", 32'(busy4), 32'h0);

    // AES-192, with a same-address read/write collision on word 4
    raddr4 = 7'd4;
    start4_go(2'd1, K192);
    for (int j = 0; j < 4; j++) tick();
    tick();
    chk("t2_rd_old", rdata4, 32'ha0fafe17);
    tick();
    chk("t2_rd_new", rdata4, 32'h62f8ead2);
    wait_done4(7, cnt);
    chk("t2_cycles", 32'(cnt), 32'd53);
    chk("t2_nr", 32'(nr4), 32'd12);
    tick();
    read4(7'd6, d);  chk("t2_w6", d, 32'hfe0c91f7);
    read4(7'd51, d); chk("t2_w51", d, 32'h01002202);

    // AES-256 with a start pulsed mid-expansion
    start4_go(2'd2, K256);
    for (int j = 0; j < 9; j++) tick();
    klen4 = 2'd0; key4 = K128; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t4_busy_mid", 32'(busy4), 32'h1);
    wait_done4(11, cnt);
    chk("t3_cycles", 32'(cnt), 32'd61);
    chk("t3_nr", 32'(nr4), 32'd14);
    tick();
    read4(7'd0, d);  chk("t3_w0", d, 32'h603deb10);
    read4(7'd8, d);  chk("t3_w8", d, 32'h9ba35411);
    read4(7'd12, d); chk("t3_w12", d, 32'ha8b09c1a);
    read4(7'd59, d); chk("t3_w59", d, 32'h706c631e);

    // Reset in the middle of an AES-128 expansion
    start4_go(2'd0, K128);
    for (int j = 0; j < 20; j++) tick();
    reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy4), 32'h0);
    chk("t5_done", 32'(done4), 32'h0);
    chk("t5_nr", 32'(nr4), 32'h0);
    chk("t5_rdata", rdata4, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    start4_go(2'd0, K128);
    wait_done4(1, cnt);
    chk("t5_cycles", 32'(cnt), 32'd45);
    tick();
    read4(7'd43, d); chk("t5_w43", d, 32'hb6630ca6);

    // NB=8, 128-bit key: 120 words against the reference model
    build_model(K128);
    klen8 = 2'd0; key8 = K128; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cnt = 1;
    while (done8 !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("t6_cycles", 32'(cnt), 32'd121);
    chk("t6_nr", 32'(nr8), 32'd14);
    tick();
    read8(7'd43, d); chk("t6_w43", d, 32'hb6630ca6);
    for (int j = 0; j < 120; j++) begin
      read8(7'(j), d);
      chk($sformatf("t6_w%0d", j), d, m8[j]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
